// File: rtl/fft_result_streamer_pkg.sv
// fft_result_streamer_pkg: shared FFT constants, stream beat type and bit reversal
package fft_result_streamer_pkg;
  localparam int N_LOG2 = 10;
  localparam int DW_COMPLEX = 32;
  localparam logic [N_LOG2:0] N_BINS = {1'b1, {N_LOG2{1'b0}}};
  localparam logic [N_LOG2:0] LAST_K = {1'b0, {N_LOG2{1'b1}}};
  typedef struct packed {
    logic signed [DW_COMPLEX/2-1:0] r;
    logic signed [DW_COMPLEX/2-1:0] i;
  } complex_t;
  typedef struct packed {
    complex_t data;
    logic [N_LOG2-1:0] idx;
    logic last;
  } stream_beat_t;
  localparam int BEAT_W = $bits(stream_beat_t);
  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
    logic [N_LOG2-1:0] r;
    for (int b = 0; b < N_LOG2; b++) r[b] = a[N_LOG2-1-b];
    return r;
  endfunction
endpackage

// File: rtl/fft_result_streamer_fifo.sv
// fft_result_streamer_fifo: two-entry beat FIFO allowing simultaneous push and pop
module fft_result_streamer_fifo
  import fft_result_streamer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [BEAT_W-1:0] din,
  output logic [BEAT_W-1:0] head,
  output logic [1:0]        cnt,
  output logic              empty
);
  logic [BEAT_W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;
  logic rd, wr, slot;
  assign rd = pop && cnt_q != 2'd0;
  assign wr = push && (cnt_q != 2'd2 || rd);
  assign slot = (cnt_q - 2'(rd)) != 2'd0;
  always_comb begin
    e0_d = wr && !slot ? din : rd ? e1_q : e0_q;
    e1_d = wr && slot ? din : e1_q;
    cnt_d = cnt_q + 2'(wr) - 2'(rd);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q <= '0;
      e1_q <= '0;
      cnt_q <= '0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      cnt_q <= cnt_d;
    end
  end
  assign head = e0_q;
  assign cnt = cnt_q;
  assign empty = cnt_q == 2'd0;
endmodule

// File: rtl/fft_result_streamer.sv
// fft_result_streamer: streams the final FFT bank out in natural bin order over valid/ready
module fft_result_streamer
  import fft_result_streamer_pkg::*;
#(
  parameter bit BIT_REV = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  src_bank,
  output logic                  ram0_en,
  output logic [N_LOG2-1:0]     ram0_addr,
  input  logic [DW_COMPLEX-1:0] ram0_dout,
  output logic                  ram1_en,
  output logic [N_LOG2-1:0]     ram1_addr,
  input  logic [DW_COMPLEX-1:0] ram1_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DW_COMPLEX-1:0] m_data,
  output logic [N_LOG2-1:0]     m_index,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  state_t state_q, state_d;
  logic [N_LOG2:0] k_q, k_d;
  logic [N_LOG2-1:0] tag_idx_q, tag_idx_d, addr;
  logic bank_q, bank_d, inflight_q, inflight_d, tag_last_q, tag_last_d;
  logic busy_q, busy_d, done_q, done_d;
  logic issue, pop, empty;
  logic [1:0] cnt;
  logic [2:0] occ;
  stream_beat_t din, head;
  assign pop = !empty && m_ready;
  assign occ = 3'(cnt) + 3'(inflight_q) - 3'(pop);
  assign issue = state_q == RUN && occ < 3'd2;
  assign addr = BIT_REV ? bitrev(k_q[N_LOG2-1:0]) : k_q[N_LOG2-1:0];
  assign ram0_en = issue && !bank_q;
  assign ram1_en = issue && bank_q;
  assign ram0_addr = ram0_en ? addr : '0;
  assign ram1_addr = ram1_en ? addr : '0;
  assign din = {bank_q ? ram1_dout : ram0_dout, tag_idx_q, tag_last_q};
  fft_result_streamer_fifo u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(inflight_q),
    .pop(pop),
    .din(din),
    .head(head),
    .cnt(cnt),
    .empty(empty)
  );
  always_comb begin
    state_d = state_q;
    k_d = state_q == IDLE ? '0 : k_q + (N_LOG2+1)'(issue);
    bank_d = state_q == IDLE && start ? src_bank : bank_q;
    inflight_d = issue;
    tag_idx_d = issue ? k_q[N_LOG2-1:0] : tag_idx_q;
    tag_last_d = issue ? k_q == LAST_K : tag_last_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: state_d = start ? RUN : IDLE;
      RUN: state_d = k_d == N_BINS ? DRAIN : RUN;
      DRAIN: begin
        state_d = pop && head.last ? FIN : DRAIN;
        done_d = pop && head.last;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q <= '0;
      bank_q <= 1'b0;
      inflight_q <= 1'b0;
      tag_idx_q <= '0;
      tag_last_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      bank_q <= bank_d;
      inflight_q <= inflight_d;
      tag_idx_q <= tag_idx_d;
      tag_last_q <= tag_last_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign m_valid = !empty;
  assign m_data = head.data;
  assign m_index = head.idx;
  assign m_last = !empty && head.last;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_fft_result_streamer.sv
// tb_fft_result_streamer: randomized scoreboard bench for fft_result_streamer
module tb_fft_result_streamer;
  localparam int N = 1024;
  logic clk, rst_n, start, src_bank, m_ready, sel;
  logic a_en0, a_en1, b_en0, b_en1, a_mv, a_ml, a_busy, a_done, b_mv, b_ml, b_busy, b_done;
  logic [9:0] a_a0, a_a1, b_a0, b_a1, a_mi, b_mi;
  logic [31:0] a_d0, a_d1, b_d0, b_d1, a_md, b_md;
  logic mv, ml, busy_s, done_s, en0_s, en1_s;
  logic [31:0] md, seen1, seen_last;
  logic [9:0] mi;
  logic [31:0] ram0 [N];
  logic [31:0] ram1 [N];
  logic [42:0] exp_q[$];
  int pass_cnt, total_cnt, beats, last_cnt, done_cnt, en0_cnt, en1_cnt;

  fft_result_streamer #(.BIT_REV(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .src_bank(src_bank),
    .ram0_en(a_en0), .ram0_addr(a_a0), .ram0_dout(a_d0),
    .ram1_en(a_en1), .ram1_addr(a_a1), .ram1_dout(a_d1),
    .m_valid(a_mv), .m_ready(m_ready), .m_data(a_md), .m_index(a_mi), .m_last(a_ml),
    .busy(a_busy), .done(a_done)
  );
  fft_result_streamer #(.BIT_REV(1'b0)) u_dut_nrev (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .src_bank(src_bank),
    .ram0_en(b_en0), .ram0_addr(b_a0), .ram0_dout(b_d0),
    .ram1_en(b_en1), .ram1_addr(b_a1), .ram1_dout(b_d1),
    .m_valid(b_mv), .m_ready(m_ready), .m_data(b_md), .m_index(b_mi), .m_last(b_ml),
    .busy(b_busy), .done(b_done)
  );

  assign mv = sel ? b_mv : a_mv;
  assign ml = sel ? b_ml : a_ml;
  assign md = sel ? b_md : a_md;
  assign mi = sel ? b_mi : a_mi;
  assign busy_s = sel ? b_busy : a_busy;
  assign done_s = sel ? b_done : a_done;
  assign en0_s = sel ? b_en0 : a_en0;
  assign en1_s = sel ? b_en1 : a_en1;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (a_en0) a_d0 <= ram0[a_a0];
    if (a_en1) a_d1 <= ram1[a_a1];
    if (b_en0) b_d0 <= ram0[b_a0];
    if (b_en1) b_d1 <= ram1[b_a1];
  end

  function automatic int brev(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 10; i++) begin
      r = (r << 1) | (x & 1);
      x = x >> 1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic exp_load(input bit bank);
    int a;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      a = sel ? k : brev(k);
      exp_q.push_back({bank ? ram1[a] : ram0[a], 10'(k), k == N - 1});
    end
  endtask

  initial begin
    logic stalled;
    logic [42:0] held, e;
    stalled = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) stalled = 0;
      else begin
        if (done_s) done_cnt++;
        if (en0_s) en0_cnt++;
        if (en1_s) en1_cnt++;
        if (stalled) chk("stall_hold", {mv, md, mi, ml}, {1'b1, held});
        stalled = mv && !m_ready;
        held = {md, mi, ml};
        if (mv && m_ready) begin
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_beat: got index %0d, expected no beat", mi);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("beat_k%0d", e[10:1]), {md, mi, ml}, e);
          end
          if (mi == 10'd1) seen1 = md;
          if (mi == 10'd1023) seen_last = md;
          last_cnt += int'(ml);
          beats++;
        end
      end
    end
  end

  task automatic stream(input bit bank, input int pct, input int stall0, input bit inject,
                        output int cyc, output int rd_stall);
    beats = 0; last_cnt = 0; done_cnt = 0; en0_cnt = 0; en1_cnt = 0; rd_stall = 0;
    exp_load(bank);
    start = 1;
    src_bank = bank;
    cyc = 0;
    m_ready = stall0 == 0 && $urandom_range(99) < pct;
    while (!done_s && cyc < 6000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == stall0) rd_stall = en0_cnt + en1_cnt;
      start = inject && (cyc == 300 || cyc == 700);
      src_bank = inject ? 1'($urandom_range(1)) : bank;
      m_ready = cyc >= stall0 && $urandom_range(99) < pct;
    end
    chk("done_in_time", cyc < 6000, 1);
    start = 0;
    m_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    chk("beat_count", beats, N);
    chk("last_count", last_cnt, 1);
    chk("done_pulses", done_cnt, 1);
  endtask

  initial begin
    int cyc, rd, g;
    pass_cnt = 0; total_cnt = 0; beats = 0; last_cnt = 0; done_cnt = 0;
    en0_cnt = 0; en1_cnt = 0; seen1 = 0; seen_last = 0;
    rst_n = 0; start = 0; src_bank = 0; m_ready = 0; sel = 0;
    for (int j = 0; j < N; j++) begin
      ram0[j] = 32'(j);
      ram1[j] = 32'h8000_0000 | $urandom;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1;
    chk("rst_m_valid", a_mv, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_m_last", a_ml, 0);
    chk("rst_m_data", a_md, 0);
    chk("rst_m_index", a_mi, 0);
    chk("rst_ram_en", {a_en0, a_en1, b_en0, b_en1}, 0);

    stream(0, 100, 0, 0, cyc, rd);
    chk("done_latency_b0", cyc, N + 3);
    chk("bin1_data", seen1, 512);
    chk("bin1023_data", seen_last, 1023);
    chk("bank0_reads", en0_cnt, N);
    chk("bank1_reads_b0", en1_cnt, 0);

    stream(1, 100, 0, 0, cyc, rd);
    chk("done_latency_b1", cyc, N + 3);
    chk("bank0_reads_b1", en0_cnt, 0);
    chk("bank1_reads", en1_cnt, N);

    stream(0, 50, 0, 0, cyc, rd);

    stream(1, 100, 0, 1, cyc, rd);
    chk("done_latency_inject", cyc, N + 3);

    beats = 0;
    exp_load(0);
    start = 1; src_bank = 0; m_ready = 1;
    @(posedge clk);
    #1 start = 0;
    g = 0;
    while (beats < 300 && g < 3000) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("reach_beat300", beats, 300);
    rst_n = 0;
    #1;
    chk("async_rst_valid", mv, 0);
    chk("async_rst_busy", busy_s, 0);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk);
    #1;
    stream(0, 70, 0, 0, cyc, rd);

    sel = 1;
    stream(0, 100, 20, 0, cyc, rd);
    chk("stall_reads_le2", rd >= 1 && rd <= 2, 1);
    stream(1, 60, 0, 0, cyc, rd);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
